prod_bcd_conv: RTL and testbench

Sequential signed-binary-to-BCD converter that sits directly downstream of the 8x8 Booth multiplier. It takes the 16-bit two's-complement product and produces a sign flag plus five BCD digits for the seven-segment display stage. Conversion uses the shift-add-3 (double-dabble) algorithm, one bit per clock, behind a start/done handshake.

---
 rtl/prod_bcd_conv_pkg.sv | 22 ++
 rtl/prod_bcd_conv_bcd_digit_adj.sv | 10 +
 rtl/prod_bcd_conv.sv | 117 +++++++++++
 tb/tb_prod_bcd_conv.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/prod_bcd_conv_pkg.sv
// Shared definitions for the multiplier product path: state encodings, widths
// and the signed-to-magnitude helper used when a conversion is accepted.
package prod_bcd_conv_pkg;

  localparam int PROD_W     = 16;
  localparam int BCD_DIGITS = 5;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  localparam logic [3:0] ITER_LAST = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 16'h8000 maps to itself, which is exactly 32768 when read as unsigned.
  function automatic logic [PROD_W-1:0] f_magnitude(input logic [PROD_W-1:0] v);
    return v[PROD_W-1] ? (~v + 16'd1) : v;
  endfunction

endpackage

// File: rtl/prod_bcd_conv_bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_digit_adj (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/prod_bcd_conv.sv
// Sequential signed 16-bit to sign + 5-digit BCD converter (shift-add-3, one bit
// per clock) with a start/busy/done handshake.
module prod_bcd_conv
  import prod_bcd_conv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] prod,
  output logic        busy,
  output logic        done,
  output logic        neg,
  output logic [19:0] bcd
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_iter;
  logic [PROD_W-1:0]  r_mag;
  logic [BCD_W-1:0]   r_scratch;
  logic               r_neg_cap;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_neg;
  logic               r_busy;
  logic               r_done;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_shift;
  logic               w_accept;
  logic               w_last;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_scratch[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // Corrected digits shifted left, pulling in the next magnitude bit (MSB first).
  assign w_shift = {w_adj[BCD_W-2:0], r_mag[PROD_W-1]};

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_CONV;
          w_accept    = 1'b1;
        end
      end
      ST_CONV: begin
        if (r_iter == ITER_LAST) begin
          w_state_nxt = ST_DONE;
          w_last      = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_CONV;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iter    <= '0;
      r_mag     <= '0;
      r_scratch <= '0;
      r_neg_cap <= 1'b0;
      r_bcd     <= '0;
      r_neg     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // Flags follow the next state so they line up with it without extra decode.
      r_busy <= (w_state_nxt == ST_CONV);
      r_done <= (w_state_nxt == ST_DONE);

      if (w_accept) begin
        r_neg_cap <= prod[PROD_W-1];
        r_mag     <= f_magnitude(prod);
        r_scratch <= '0;
        r_iter    <= '0;
      end else if (r_state == ST_CONV) begin
        r_scratch <= w_shift;
        r_mag     <= {r_mag[PROD_W-2:0], 1'b0};
        r_iter    <= r_iter + 4'd1;
      end

      if (w_last) begin
        r_bcd <= w_shift;
        r_neg <= r_neg_cap;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign neg  = r_neg;
  assign bcd  = r_bcd;

endmodule

// File: tb/tb_prod_bcd_conv.sv
// Directed bench for prod_bcd_conv: hand-computed BCD results, handshake timing,
// back-to-back starts, ignored mid-conversion start and asynchronous abort.
module tb_prod_bcd_conv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] prod;
  logic        busy;
  logic        done;
  logic        neg;
  logic [19:0] bcd;

  int n_cmp;
  int n_err;

  prod_bcd_conv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .prod  (prod),
    .busy  (busy),
    .done  (done),
    .neg   (neg),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one conversion and check latency, busy width, result and done width.
  task automatic convert(input string tag, input logic [15:0] p,
                         input logic [19:0] exp_bcd, input logic exp_neg);
    int lat;
    int nbusy;
    @(negedge clk);
    prod  = p;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat   = 0;
    nbusy = 0;
    @(negedge clk);
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"},   lat,     16);
    chk({tag, "_busyn"}, nbusy,   16);
    chk({tag, "_bcd"},   bcd,     exp_bcd);
    chk({tag, "_neg"},   neg,     exp_neg);
    chk({tag, "_busy0"}, busy,    0);
    @(negedge clk);
    chk({tag, "_done1"}, done,    0);
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    prod  = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_neg",  neg,  0);
    chk("rst_bcd",  bcd,  0);
    rst_n = 1'b1;
    @(negedge clk);

    convert("zero", 16'h0000, 20'h00000, 1'b0);
    convert("maxp", 16'h7FFF, 20'h32767, 1'b0);
    convert("minn", 16'h8000, 20'h32768, 1'b1);
    convert("m1",   16'hFFFF, 20'h00001, 1'b1);
    chk("hold_bcd", bcd, 20'h00001);

    // Back-to-back: start stays high into DONE, second operand already present.
    @(negedge clk);
    prod  = 16'hFFAC;
    start = 1'b1;
    @(posedge clk);
    #1 prod = 16'h0064;
    n = 0;
    @(negedge clk);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_lat1", n, 16);
    chk("b2b_bcd1", bcd, 20'h00084);
    chk("b2b_neg1", neg, 1);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      if (n == 1) #1 start = 1'b0;
      @(negedge clk);
    end while (!done && n < 40);
    chk("b2b_gap",  n, 17);
    chk("b2b_bcd2", bcd, 20'h00100);
    chk("b2b_neg2", neg, 0);
    @(negedge clk);
    chk("b2b_done_end", done, 0);

    // Start during CONV must be ignored and must not re-sample prod.
    @(negedge clk);
    prod  = 16'h1234;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    prod  = 16'h0001;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    @(negedge clk);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ign_lat", n, 10);
    chk("ign_bcd", bcd, 20'h04660);
    chk("ign_neg", neg, 0);
    repeat (3) @(negedge clk);
    chk("ign_nobusy", busy, 0);
    chk("ign_bcdhold", bcd, 20'h04660);

    // Asynchronous abort mid-conversion.
    @(negedge clk);
    prod  = 16'h8000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bcd",  bcd,  0);
    chk("abort_neg",  neg,  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    chk("abort_quiet", n, 0);
    convert("k1000", 16'h03E8, 20'h01000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
